// File: rtl/entrada_pkg.sv
// Shared definitions for the Entrada input path: FSM encoding and debounce defaults.
// Optional feature macro: ENTRADA_PRESS_COUNT_EN (adds press_count output).
package entrada_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        WAIT_RELEASE = 2'd2,
        VALID        = 2'd3
    } state_t;

    localparam int DEB_CYCLES_BOARD = 500000;
    localparam int DEB_CYCLES_SIM   = 4;

endpackage

// File: rtl/debounce_sinc.sv
// Two-flop synchronizer plus stability counter for one raw active-low key.
// Optional feature macro: ENTRADA_PRESS_COUNT_EN (not used here).
module debounce_sinc #(
    parameter int DEB_CYCLES = 500000,
    parameter int CNT_W      = 20
) (
    input  logic clk0,
    input  logic reset,
    input  logic raw,
    output logic clean
);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk0) begin
        if (!reset) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            cnt   <= '0;
            clean <= 1'b1;
        end else begin
            s1 <= raw;
            s2 <= s1;
            // any return to the current clean level restarts the stability window
            if (s2 == clean) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
                clean <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/modulo_entrada_botao.sv
// Entrada input stage: debounced key, synced switches, 4-phase rd_req/data_valid handshake.
// Optional feature macro: ENTRADA_PRESS_COUNT_EN (adds 8-bit press_count output).
module modulo_entrada_botao
    import entrada_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_BOARD,
    parameter int CNT_W      = 20,
    parameter int DATA_W     = 16
) (
    input  logic              clk0,
    input  logic              reset,
    input  logic              ent,
    input  logic [DATA_W-1:0] switch,
    input  logic              rd_req,
`ifdef ENTRADA_PRESS_COUNT_EN
    output logic [7:0]        press_count,
`endif
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              ent_clean
);

    state_t            state;
    state_t            next;
    logic              capture;
    logic              armed;
    logic [DATA_W-1:0] sw_m;
    logic [DATA_W-1:0] sw_s;

    debounce_sinc #(
        .DEB_CYCLES(DEB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_deb_ent (
        .clk0 (clk0),
        .reset(reset),
        .raw  (ent),
        .clean(ent_clean)
    );

    always_ff @(posedge clk0) begin
        if (!reset) begin
            sw_m <= '1;
            sw_s <= '1;
        end else begin
            sw_m <= switch;
            sw_s <= sw_m;
        end
    end

    always_comb begin
        next    = state;
        capture = 1'b0;
        unique case (state)
            IDLE: begin
                if (rd_req) next = WAIT_PRESS;
            end
            WAIT_PRESS: begin
                if (!rd_req)
                    next = IDLE;
                else if (armed && !ent_clean)
                    next = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (!rd_req) begin
                    next = IDLE;
                end else if (ent_clean) begin
                    next    = VALID;
                    capture = 1'b1;
                end
            end
            VALID: begin
                if (!rd_req) next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    // armed: key seen released since entering WAIT_PRESS, so a held key is ignored
    always_ff @(posedge clk0) begin
        if (!reset) begin
            state      <= IDLE;
            armed      <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            state      <= next;
            armed      <= (state == WAIT_PRESS) && (next == WAIT_PRESS)
                          && (armed || ent_clean);
            data_valid <= (next == VALID);
            if (capture) data_out <= sw_s;
        end
    end

`ifdef ENTRADA_PRESS_COUNT_EN
    always_ff @(posedge clk0) begin
        if (!reset)
            press_count <= 8'd0;
        else if (capture)
            press_count <= press_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_modulo_entrada_botao.sv
// Directed bench for modulo_entrada_botao with DEB_CYCLES=4, CNT_W=3.
// Optional feature macro: ENTRADA_PRESS_COUNT_EN (enables press_count checks).
module tb_modulo_entrada_botao;

    logic        clk0 = 1'b0;
    logic        reset;
    logic        ent;
    logic [15:0] switch;
    logic        rd_req;
    logic [15:0] data_out;
    logic        data_valid;
    logic        ent_clean;
`ifdef ENTRADA_PRESS_COUNT_EN
    logic [7:0]  press_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int n_cap   = 0;

    always #5 clk0 = ~clk0;

    modulo_entrada_botao #(
        .DEB_CYCLES(4),
        .CNT_W     (3),
        .DATA_W    (16)
    ) dut (
        .clk0       (clk0),
        .reset      (reset),
        .ent        (ent),
        .switch     (switch),
        .rd_req     (rd_req),
`ifdef ENTRADA_PRESS_COUNT_EN
        .press_count(press_count),
`endif
        .data_out   (data_out),
        .data_valid (data_valid),
        .ent_clean  (ent_clean)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk0);
        #1;
    endtask

    task automatic press();
        ent = 1'b0;
        tick(8);
        ent = 1'b1;
        tick(8);
    endtask

    task automatic capture(input logic [15:0] w);
        switch = w;
        rd_req = 1'b1;
        tick(2);
        press();
        chk("cap_dv", {31'd0, data_valid}, 32'd1);
        chk("cap_data", {16'd0, data_out}, {16'd0, w});
        n_cap++;
        rd_req = 1'b0;
        tick(1);
    endtask

    initial begin
        reset  = 1'b0;
        ent    = 1'b0;
        rd_req = 1'b1;
        switch = 16'hFFFF;
        tick(2);
        chk("rst_data", {16'd0, data_out}, 32'h0);
        chk("rst_dv", {31'd0, data_valid}, 32'd0);
        chk("rst_clean", {31'd0, ent_clean}, 32'd1);
        ent    = 1'b1;
        rd_req = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(3);
        chk("idle_dv", {31'd0, data_valid}, 32'd0);

        // press timing: ent_clean falls on 6th edge, data_valid one edge after rise
        rd_req = 1'b1;
        switch = 16'hA5C3;
        tick(2);
        ent = 1'b0;
        tick(5);
        chk("deb_edge5", {31'd0, ent_clean}, 32'd1);
        tick(1);
        chk("deb_edge6", {31'd0, ent_clean}, 32'd0);
        tick(6);
        ent = 1'b1;
        tick(5);
        chk("rel_edge5", {31'd0, ent_clean}, 32'd0);
        tick(1);
        chk("rel_edge6", {31'd0, ent_clean}, 32'd1);
        chk("dv_not_yet", {31'd0, data_valid}, 32'd0);
        tick(1);
        chk("dv_rise", {31'd0, data_valid}, 32'd1);
        chk("data_a5c3", {16'd0, data_out}, 32'hA5C3);
        n_cap++;
        rd_req = 1'b0;
        tick(1);
        chk("dv_fall", {31'd0, data_valid}, 32'd0);
        chk("data_hold", {16'd0, data_out}, 32'hA5C3);

        // short glitches are filtered
        rd_req = 1'b1;
        tick(2);
        for (int i = 0; i < 5; i++) begin
            ent = 1'b0;
            tick(3);
            ent = 1'b1;
            tick(5);
            chk("glitch_clean", {31'd0, ent_clean}, 32'd1);
        end
        chk("glitch_dv", {31'd0, data_valid}, 32'd0);
        rd_req = 1'b0;
        tick(1);

        // press with no request, then request: no capture
        switch = 16'h1234;
        press();
        chk("noreq_dv", {31'd0, data_valid}, 32'd0);
        rd_req = 1'b1;
        tick(3);
        chk("late_req_dv", {31'd0, data_valid}, 32'd0);
        press();
        chk("late_req_cap", {31'd0, data_valid}, 32'd1);
        chk("late_req_data", {16'd0, data_out}, 32'h1234);
        n_cap++;
        rd_req = 1'b0;
        tick(1);

        // key held across request rise
        ent = 1'b0;
        tick(8);
        rd_req = 1'b1;
        tick(3);
        ent = 1'b1;
        tick(8);
        chk("held_dv", {31'd0, data_valid}, 32'd0);
        chk("held_data", {16'd0, data_out}, 32'h1234);
        switch = 16'hBEEF;
        press();
        chk("held_cap", {31'd0, data_valid}, 32'd1);
        chk("held_cap_data", {16'd0, data_out}, 32'hBEEF);
        n_cap++;
        rd_req = 1'b0;
        tick(1);

        // abort in WAIT_RELEASE, simultaneous with release
        capture(16'h1234);
        rd_req = 1'b1;
        switch = 16'h5555;
        tick(2);
        ent = 1'b0;
        tick(8);
        ent = 1'b1;
        tick(6);
        chk("abort_clean", {31'd0, ent_clean}, 32'd1);
        rd_req = 1'b0;
        tick(1);
        chk("abort_dv", {31'd0, data_valid}, 32'd0);
        tick(3);
        chk("abort_data", {16'd0, data_out}, 32'h1234);

        // switches move while VALID
        switch = 16'h1234;
        rd_req = 1'b1;
        tick(2);
        press();
        n_cap++;
        switch = 16'hFFFF;
        tick(5);
        chk("valid_dv", {31'd0, data_valid}, 32'd1);
        chk("valid_hold", {16'd0, data_out}, 32'h1234);
        rd_req = 1'b0;
        tick(1);
        chk("valid_exit", {31'd0, data_valid}, 32'd0);

`ifdef ENTRADA_PRESS_COUNT_EN
        chk("pc_pre", {24'd0, press_count}, n_cap & 32'hFF);
        for (int i = 0; i < 257; i++) capture(16'(i));
        for (int i = 0; i < 3; i++) begin
            rd_req = 1'b1;
            tick(2);
            ent = 1'b0;
            tick(8);
            rd_req = 1'b0;
            tick(1);
            ent = 1'b1;
            tick(8);
        end
        chk("pc_wrap", {24'd0, press_count}, n_cap & 32'hFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
